// File: rtl/instr_ram_ctrl_if.sv
// rtl/instr_ram_ctrl_if.sv - UART byte stream in, instruction RAM write/address port out
interface instr_ram_ctrl_if #(
  parameter int N = 8
);
  logic         rx_valid;
  logic [N-1:0] rx_data;
  logic [N-1:0] ram_addr;
  logic         ram_we;
  logic [N-1:0] ram_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output ram_addr,
    output ram_we,
    output ram_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  ram_addr,
    input  ram_we,
    input  ram_wdata
  );
endinterface

// File: rtl/instr_ram_ctrl.sv
// rtl/instr_ram_ctrl.sv - instruction RAM sequencer: UART load, free-run and single-step replay
// Optional XOR checksum of stored bytes: define INSTR_CTRL_CHECKSUM_EN.
module instr_ram_ctrl #(
  parameter int           N           = 8,
  parameter int           MAX_ADDRESS = 255,
  parameter logic [N-1:0] DELIM       = N'('h24),
  parameter logic [N-1:0] END_BYTE    = N'('h0A)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             debug_btn,
  instr_ram_ctrl_if.master bus,
  output logic [N:0]       prog_len,
  output logic             instr_valid,
  output logic             at_end,
  output logic             overflow,
  output logic             load_done,
  output logic [N-1:0]     checksum
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DEBUG = 2'd2;
  localparam logic [1:0] S_IDLE  = 2'd3;

  localparam logic [N:0] FULL_LEN = (N+1)'(MAX_ADDRESS + 1);
  localparam logic [N:0] ONE      = {{N{1'b0}}, 1'b1};

  logic [1:0]   state;
  logic [1:0]   next_state;
  logic         btn_prev;
  logic [N-1:0] addr_q;
  logic         we_q;
  logic [N-1:0] wdata_q;
  logic [N:0]   len_q;
  logic         ovf_q;
  logic         done_q;

  logic         entering;
  logic         byte_take;
  logic         is_delim;
  logic         is_end;
  logic         is_full;
  logic         do_write;
  logic         btn_rise;
  logic [N:0]   addr_next;
  logic         step_ok;
  logic         replay_state;

  always_comb begin
    next_state = S_IDLE;
    case (mode)
      2'd0:    next_state = S_RUN;
      2'd1:    next_state = S_LOAD;
      2'd2:    next_state = S_DEBUG;
      default: next_state = S_IDLE;
    endcase
  end

  assign entering  = (next_state != state);
  assign byte_take = (state == S_LOAD) && bus.rx_valid && !done_q;
  assign is_delim  = (bus.rx_data == DELIM);
  assign is_end    = (bus.rx_data == END_BYTE);
  assign is_full   = (len_q == FULL_LEN);
  assign do_write  = byte_take && !is_delim && !is_end && !is_full;
  assign btn_rise  = debug_btn && !btn_prev;

  // Stepping is allowed only while addr+1 is still inside the program;
  // with prog_len = 0 this is never true, so the address stays at 0.
  assign addr_next = {1'b0, addr_q} + ONE;
  assign step_ok   = (addr_next < len_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      btn_prev <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= next_state;
      btn_prev <= debug_btn;
      we_q     <= 1'b0;

      case (state)
        S_LOAD: begin
          if (byte_take) begin
            if (is_end) begin
              done_q <= 1'b1;
            end else if (!is_delim) begin
              if (is_full) begin
                ovf_q <= 1'b1;
              end else begin
                we_q    <= 1'b1;
                addr_q  <= len_q[N-1:0];
                wdata_q <= bus.rx_data;
                len_q   <= len_q + ONE;
              end
            end
          end
        end
        S_RUN: begin
          // A write still draining from the exit edge of LOAD held the
          // address; restart replay from 0 right after it.
          if (we_q) begin
            addr_q <= '0;
          end else if (step_ok) begin
            addr_q <= addr_next[N-1:0];
          end
        end
        S_DEBUG: begin
          if (we_q) begin
            addr_q <= '0;
          end else if (btn_rise && step_ok) begin
            addr_q <= addr_next[N-1:0];
          end
        end
        default: begin
        end
      endcase

      if (entering) begin
        if (next_state == S_LOAD) begin
          len_q  <= '0;
          addr_q <= '0;
          ovf_q  <= 1'b0;
          done_q <= 1'b0;
        end else if ((next_state == S_RUN || next_state == S_DEBUG) && !do_write) begin
          addr_q <= '0;
        end
      end
    end
  end

`ifdef INSTR_CTRL_CHECKSUM_EN
  logic [N-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      csum_q <= '0;
    end else if (entering && next_state == S_LOAD) begin
      csum_q <= '0;
    end else if (do_write) begin
      csum_q <= csum_q ^ bus.rx_data;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign replay_state  = (state == S_RUN) || (state == S_DEBUG);
  assign instr_valid   = replay_state && (len_q != '0);
  assign at_end        = instr_valid && (addr_next == len_q);

  assign bus.ram_addr  = addr_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_wdata = wdata_q;
  assign prog_len      = len_q;
  assign overflow      = ovf_q;
  assign load_done     = done_q;

endmodule

// File: doc/instr_ram_ctrl.md
# instr_ram_ctrl

Sequencer that owns the instruction RAM's address and write ports. It loads a program streamed byte-by-byte from the UART receiver, then replays it in one of two ways: free-running (one address per clock) or single-stepped from the debug button. It sits between the UART RX block, the mode switches and the instruction RAM, and replaces the RAM's internal address counter with explicit, checkable addressing.

## Interface
- N, 8, data and address width
- MAX_ADDRESS, 255, highest writable RAM address
- DELIM, 'h24, separator byte; never stored
- END_BYTE, 'h0A, terminates a load

- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-low reset
- mode  in  2  0 = run, 1 = load, 2 = debug, 3 = idle
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  N  received UART byte
- debug_btn  in  1  step button, already synchronised/debounced, level
- ram_addr  out  N  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  N  RAM write data
- prog_len  out  N+1  number of bytes stored by the last load
- instr_valid  out  1  ram_addr points inside the loaded program
- at_end  out  1  ram_addr == prog_len-1 in RUN/DEBUG
- overflow  out  1  sticky; a byte was dropped because the RAM was full
- load_done  out  1  END_BYTE seen in the current load
- checksum  out  N  XOR of stored bytes (see Configuration)

## Operation
- FSM states are IDLE, LOAD, RUN and DEBUG. The next state is decoded from `mode` every clock; 3 maps to IDLE.
- The state register updates on the clock edge. Behaviour in any cycle is decided by the current state, not by `mode`.
- Entering LOAD from any other state clears prog_len, ram_addr, overflow, load_done and checksum.
- LOAD, byte handling, when rx_valid=1 and load_done=0:
  - A byte equal to DELIM is ignored.
  - A byte equal to END_BYTE sets load_done. No write occurs.
  - Any other byte is written at address prog_len, then prog_len increments.
- LOAD, full RAM: if prog_len == MAX_ADDRESS+1, the byte is dropped and overflow is set.
- LOAD, after load_done: all bytes are ignored until LOAD is re-entered.
- Entering RUN or DEBUG sets ram_addr to 0.
- RUN: ram_addr increments every clock until it reaches prog_len-1, then holds there. No wrap.
- DEBUG: ram_addr increments once per rising edge of debug_btn (registered previous value 0, current 1), saturating at prog_len-1. Holding the button high gives only one step.
- IDLE: ram_addr holds its value, ram_we=0.
- instr_valid = state is RUN or DEBUG and prog_len != 0.
- at_end = instr_valid and ram_addr == prog_len-1.
- Empty program (prog_len=0): in RUN/DEBUG, ram_addr stays 0 and instr_valid=0.
- ram_we is asserted only in LOAD.

## Timing
- Reset values (rst=0 at a clock edge): state IDLE, ram_addr 0, ram_we 0, ram_wdata 0, prog_len 0, overflow 0, load_done 0, checksum 0, button edge register 0.
- Reset mid-load discards the program: prog_len=0.
- Load write latency is 1 cycle. A byte sampled at edge k drives ram_we=1, ram_addr=prog_len(old) and ram_wdata=byte for the cycle after edge k. The RAM captures it at edge k+1.
- Back-to-back rx_valid on consecutive cycles is supported at full rate.
- rx_valid on the same edge at which mode leaves LOAD: the byte is still accepted, because the state was LOAD.
- RUN: the first address (0) is presented in the cycle after entry. Address a is presented a cycles later.
- DEBUG step latency: button rising edge sampled at edge k updates ram_addr after edge k.
- No handshake back to UART. The block is always ready.

## Configuration
- INSTR_CTRL_CHECKSUM_EN defined:
  - checksum XOR-accumulates every byte actually written.
  - The update is registered in the same cycle as ram_we.
  - Dropped, DELIM and END_BYTE bytes are excluded.
- INSTR_CTRL_CHECKSUM_EN undefined: checksum is tied to 0 and no accumulator register exists.

## Test plan
- Reset: hold rst=0 for 2 cycles with rx_valid toggling -> all outputs 0, state IDLE.
- Load: mode=1, stream 4A 24 4B 24 4C 24 4D 24 0A -> four writes at addr 0..3 with data 4A,4B,4C,4D; prog_len=4, load_done=1; checksum=0x00 with the macro, 0 without; the DELIM bytes produce no writes.
- Run: mode=0 after the load -> ram_addr 0,1,2,3 on successive cycles, then held at 3 with at_end=1 for at least 5 further cycles.
- Debug:
  - mode=2 -> ram_addr=0.
  - Apply 3 one-cycle presses -> ram_addr 1,2,3.
  - 4 more presses -> ram_addr stays 3.
  - Button held high for 10 cycles -> exactly one step.
- Overflow: with MAX_ADDRESS=3, load 5 non-delimiter bytes -> prog_len=4, overflow=1, exactly 4 writes.
- Boundaries:
  - Assert rst=0 mid-load, then enter RUN -> instr_valid=0, ram_addr=0.
  - Change mode on the same edge as rx_valid -> the byte is written.
